// File: rtl/bias_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bias_pkg : shared constants for the bias vector buffer                     |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
package bias_pkg;

    localparam int DWIDTH_DEF = 16;
    localparam int PE_NUM_DEF = 8;
    localparam int DEPTH_DEF  = 32;

    // Stream controller states
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

endpackage
`default_nettype wire

// File: rtl/bias_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bias_buffer_if : load, stream-control and bias-output bundle               |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
interface bias_buffer_if
    import bias_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int PE_NUM = PE_NUM_DEF,
    parameter int DEPTH  = DEPTH_DEF
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

    logic                     ld_en;
    logic [AW-1:0]            ld_addr;
    logic [LW-1:0]            ld_lane;
    logic [DWIDTH-1:0]        ld_data;
    logic                     start;
    logic [AW-1:0]            base_addr;
    logic [AW:0]              count;
    logic [PE_NUM*DWIDTH-1:0] bias_data;
    logic [AW-1:0]            bias_addr;
    logic                     bias_valid;
    logic                     bias_ready;
    logic                     busy;
    logic                     done;

    modport slave (
        input  ld_en, ld_addr, ld_lane, ld_data,
        input  start, base_addr, count, bias_ready,
        output bias_data, bias_addr, bias_valid, busy, done
    );

    modport master (
        output ld_en, ld_addr, ld_lane, ld_data,
        output start, base_addr, count, bias_ready,
        input  bias_data, bias_addr, bias_valid, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/bias_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bias_mem : DEPTH x PE_NUM lane-writable store, registered read-before-write|
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module bias_mem
    import bias_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int PE_NUM = PE_NUM_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH),
    parameter int LW     = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     i_wr_en,
    input  wire logic [AW-1:0]            i_wr_addr,
    input  wire logic [LW-1:0]            i_wr_lane,
    input  wire logic [DWIDTH-1:0]        i_wr_data,
    input  wire logic                     i_rd_en,
    input  wire logic [AW-1:0]            i_rd_addr,
    output      logic [PE_NUM*DWIDTH-1:0] o_rd_data
);

    logic [PE_NUM*DWIDTH-1:0] r_mem [DEPTH];
    logic [PE_NUM*DWIDTH-1:0] r_rd_data;
    logic                     w_wr_ok;

    // Out-of-range lanes are dropped rather than aliased onto a real lane
    assign w_wr_ok = i_wr_en && (int'(i_wr_lane) < PE_NUM) && (int'(i_wr_addr) < DEPTH);

    always_ff @(posedge clk) begin
        if (rst_n && w_wr_ok) begin
            r_mem[i_wr_addr][int'(i_wr_lane)*DWIDTH +: DWIDTH] <= i_wr_data;
        end
    end

    // Read register doubles as the held output vector; storage itself is never reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/bias_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bias_buffer : streams stored bias vectors to the PE array with handshake   |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module bias_buffer
    import bias_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int PE_NUM = PE_NUM_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    bias_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

    localparam logic [AW:0]   c_CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DEPTH - 1);

    logic [0:0]               r_state;
    logic [AW-1:0]            r_addr;
    logic [AW:0]              r_remain;
    logic                     r_valid;
    logic                     r_done;

    logic                     w_launch;
    logic                     w_xfer;
    logic                     w_last;
    logic                     w_rd_en;
    logic [AW-1:0]            w_next_addr;
    logic [AW-1:0]            w_rd_addr;
    logic [PE_NUM*DWIDTH-1:0] w_rd_data;

    assign w_launch    = (r_state == ST_IDLE) && bus.start && (bus.count != '0);
    assign w_xfer      = (r_state == ST_STREAM) && r_valid && bus.bias_ready;
    assign w_last      = (r_remain == c_CNT_ONE);
    assign w_next_addr = (r_addr == c_LAST_ADDR) ? '0 : r_addr + AW'(1);

    // Fetch the next vector on the same edge as the transfer so there is no bubble
    assign w_rd_en   = w_launch || (w_xfer && !w_last);
    assign w_rd_addr = w_launch ? bus.base_addr : w_next_addr;

    bias_mem #(
        .DWIDTH (DWIDTH),
        .PE_NUM (PE_NUM),
        .DEPTH  (DEPTH),
        .AW     (AW),
        .LW     (LW)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (bus.ld_en),
        .i_wr_addr (bus.ld_addr),
        .i_wr_lane (bus.ld_lane),
        .i_wr_data (bus.ld_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_remain <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.count == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state  <= ST_STREAM;
                            r_addr   <= bus.base_addr;
                            r_remain <= bus.count;
                            r_valid  <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_state  <= ST_IDLE;
                            r_valid  <= 1'b0;
                            r_remain <= '0;
                            r_done   <= 1'b1;
                        end else begin
                            r_addr   <= w_next_addr;
                            r_remain <= r_remain - c_CNT_ONE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.bias_data  = w_rd_data;
    assign bus.bias_addr  = r_addr;
    assign bus.bias_valid = r_valid;
    assign bus.busy       = (r_state == ST_STREAM);
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bias_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bias_buffer : self-checking bench for bias_buffer                       |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module tb_bias_buffer;

    localparam int DW = 16;
    localparam int PE = 8;
    localparam int DP = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bias_buffer_if #(.DWIDTH(DW), .PE_NUM(PE), .DEPTH(DP)) bus ();

    bias_buffer #(.DWIDTH(DW), .PE_NUM(PE), .DEPTH(DP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference storage: what software believes each vector holds
    logic [DW-1:0] m_mem [DP][PE];

    typedef struct {
        int base;
        int cnt;
        int mode;      // 0 ready=1, 1 random ready/writes/starts, 2 stall 2nd vector 5 cycles, 3 overwrite held vector
        int exp_xfers;
        int exp_last;
    } vec_t;

    function automatic logic [PE*DW-1:0] pack(input int v);
        logic [PE*DW-1:0] r;
        for (int l = 0; l < PE; l++) r[l*DW +: DW] = m_mem[v][l];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [PE*DW-1:0] act, input logic [PE*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stream(input int base, input int cnt, input int mode,
                              output int xfers, output int last_addr);
        int n, cyc, stall, e, wa, wl;
        bit rdy, wr;
        logic [DW-1:0] wd;
        logic [PE*DW-1:0] snap;
        xfers = 0; last_addr = -1; n = 0; cyc = 0; stall = 0;
        bus.start = 1'b1; bus.base_addr = 5'(base); bus.count = 6'(cnt);
        snap = pack(base);
        tick();
        bus.start = 1'b0;
        if (cnt == 0) begin
            chk("zero_valid", bus.bias_valid, 0);
            chk("zero_busy", bus.busy, 0);
            chk("zero_done", bus.done, 1);
            tick();
            chk("zero_done_clr", bus.done, 0);
            return;
        end
        while (n < cnt && cyc < cnt * 12 + 20) begin
            e = (base + n) % DP;
            chk("st_valid", bus.bias_valid, 1);
            chk("st_busy", bus.busy, 1);
            chk("st_done", bus.done, 0);
            chk("st_addr", bus.bias_addr, e);
            chk("st_data", bus.bias_data, snap);
            wr = 1'b0; wa = 0; wl = 0; wd = '0;
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    rdy = ($urandom % 3) != 0;
                    wr  = ($urandom % 2) != 0;
                    wa  = $urandom % DP; wl = $urandom % PE; wd = DW'($urandom);
                    bus.start = ($urandom % 4) == 0;
                    bus.base_addr = 5'($urandom); bus.count = 6'($urandom_range(0, 8));
                end
                2: rdy = !(n == 1 && stall < 5);
                default: begin
                    rdy = (stall >= 3);
                    if (n == 0 && stall == 0) begin
                        wr = 1'b1; wa = e; wl = 2; wd = 16'h7FFF;
                    end
                end
            endcase
            bus.bias_ready = rdy;
            // Next vector is fetched before any write issued in this same cycle lands
            if (rdy && n + 1 < cnt) snap = pack((base + n + 1) % DP);
            if (wr) begin
                m_mem[wa][wl] = wd;
                bus.ld_en = 1'b1; bus.ld_addr = 5'(wa); bus.ld_lane = 3'(wl); bus.ld_data = wd;
            end
            tick();
            bus.ld_en = 1'b0; bus.start = 1'b0;
            if (rdy) begin
                n++; xfers++; last_addr = e; stall = 0;
            end else begin
                stall++;
            end
            cyc++;
        end
        chk("st_xfer_count", n, cnt);
        chk("end_valid", bus.bias_valid, 0);
        chk("end_busy", bus.busy, 0);
        chk("end_done", bus.done, 1);
        tick();
        chk("end_done_clr", bus.done, 0);
        chk("end_valid2", bus.bias_valid, 0);
    endtask

    vec_t tbl[5];
    int   xf, la, rb, rc;
    logic [PE*DW-1:0] exp37;

    initial begin
        checks = 0; errors = 0;
        tbl[0] = '{base: 30, cnt: 4,  mode: 0, exp_xfers: 4,  exp_last: 1};
        tbl[1] = '{base: 0,  cnt: 0,  mode: 0, exp_xfers: 0,  exp_last: -1};
        tbl[2] = '{base: 8,  cnt: 3,  mode: 2, exp_xfers: 3,  exp_last: 10};
        tbl[3] = '{base: 5,  cnt: 1,  mode: 3, exp_xfers: 1,  exp_last: 5};
        tbl[4] = '{base: 20, cnt: 32, mode: 0, exp_xfers: 32, exp_last: 19};

        // Reset with start and ld_en active: both must be ignored
        rst_n = 1'b0;
        bus.ld_en = 1'b1; bus.ld_addr = '0; bus.ld_lane = '0; bus.ld_data = 16'h1234;
        bus.start = 1'b1; bus.base_addr = '0; bus.count = 6'd4; bus.bias_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", bus.bias_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_data", bus.bias_data, 0);
        chk("rst_addr", bus.bias_addr, 0);
        rst_n = 1'b1; bus.ld_en = 1'b0; bus.start = 1'b0;
        tick();
        chk("post_rst_valid", bus.bias_valid, 0);

        for (int v = 0; v < DP; v++) begin
            for (int l = 0; l < PE; l++) begin
                if (v == 3) m_mem[v][l] = (l % 2 == 0) ? DW'(-(l + 1)) : DW'(l + 1);
                else        m_mem[v][l] = DW'($urandom);
                bus.ld_en = 1'b1; bus.ld_addr = 5'(v); bus.ld_lane = 3'(l); bus.ld_data = m_mem[v][l];
                tick();
            end
        end
        bus.ld_en = 1'b0;

        // Single vector with signed lanes, checked against literal values
        exp37 = {16'h0008, 16'hFFF9, 16'h0006, 16'hFFFB, 16'h0004, 16'hFFFD, 16'h0002, 16'hFFFF};
        bus.bias_ready = 1'b1; bus.start = 1'b1; bus.base_addr = 5'd3; bus.count = 6'd1;
        tick();
        bus.start = 1'b0;
        chk("v3_valid", bus.bias_valid, 1);
        chk("v3_addr", bus.bias_addr, 3);
        chk("v3_data", bus.bias_data, exp37);
        tick();
        chk("v3_done", bus.done, 1);
        chk("v3_valid_off", bus.bias_valid, 0);

        for (int i = 0; i < 5; i++) begin
            run_stream(tbl[i].base, tbl[i].cnt, tbl[i].mode, xf, la);
            chk("tbl_xfers", xf, tbl[i].exp_xfers);
            if (tbl[i].exp_xfers > 0) chk("tbl_last", la, tbl[i].exp_last);
        end

        // Overwrite made while vector 5 was held becomes visible on the next fetch
        bus.bias_ready = 1'b1; bus.start = 1'b1; bus.base_addr = 5'd5; bus.count = 6'd1;
        tick();
        bus.start = 1'b0;
        chk("v5_lane2", bus.bias_data[2*DW +: DW], 16'h7FFF);
        chk("v5_full", bus.bias_data, pack(5));
        tick();
        chk("v5_done", bus.done, 1);

        // Reset mid-stream: abort without done, contents retained, writes ignored
        bus.start = 1'b1; bus.base_addr = 5'd12; bus.count = 6'd5;
        tick();
        bus.start = 1'b0;
        tick();
        chk("mid_addr", bus.bias_addr, 13);
        rst_n = 1'b0;
        bus.ld_en = 1'b1; bus.ld_addr = 5'd12; bus.ld_lane = 3'd0; bus.ld_data = ~m_mem[12][0];
        bus.start = 1'b1; bus.base_addr = 5'd0; bus.count = 6'd3;
        tick();
        chk("mid_rst_valid", bus.bias_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_data", bus.bias_data, 0);
        chk("mid_rst_addr", bus.bias_addr, 0);
        rst_n = 1'b1; bus.ld_en = 1'b0; bus.start = 1'b0;
        tick();
        chk("mid_post_done", bus.done, 0);
        chk("mid_post_valid", bus.bias_valid, 0);
        run_stream(12, 2, 0, xf, la);
        chk("mid_restream_xfers", xf, 2);

        for (int i = 0; i < 15; i++) begin
            rb = $urandom % DP;
            rc = $urandom_range(0, 8);
            run_stream(rb, rc, 1, xf, la);
            chk("rnd_xfers", xf, rc);
            if (rc > 0) chk("rnd_last", la, (rb + rc - 1) % DP);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bias_buffer.md
BIAS_BUFFER -- requirements
Module: bias_buffer

Interface
REQ-001 Parameter DWIDTH, default 16, width of one signed bias word.
REQ-002 Parameter PE_NUM, default 8, number of lanes (one bias word per PE) per vector.
REQ-003 Parameter DEPTH, default 32, number of bias vectors stored; AW = clog2(DEPTH), LW = max(1, clog2(PE_NUM)).
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 ld_en  in  1  write one lane of one stored vector this cycle.
REQ-007 ld_addr  in  AW  vector index for the lane write.
REQ-008 ld_lane  in  LW  lane index for the lane write.
REQ-009 ld_data  in  DWIDTH  signed bias word for the lane write.
REQ-010 start  in  1  single-cycle request to begin streaming.
REQ-011 base_addr  in  AW  first vector index of the stream, sampled on start.
REQ-012 count  in  AW+1  number of vectors to stream, sampled on start.
REQ-013 bias_data  out  PE_NUM*DWIDTH  signed vector; lane k occupies bits [k*DWIDTH +: DWIDTH].
REQ-014 bias_addr  out  AW  vector index currently presented on bias_data.
REQ-015 bias_valid  out  1  bias_data/bias_addr hold a valid vector.
REQ-016 bias_ready  in  1  consumer accepts the vector when high with bias_valid.
REQ-017 busy  out  1  stream in progress.
REQ-018 done  out  1  one-cycle pulse when the stream ends.

Function
REQ-019 States: IDLE, STREAM; only these two.
REQ-020 IDLE: start with count != 0 -> STREAM, busy=1 next cycle; start with count == 0 -> stays IDLE, done pulses the next cycle, bias_valid stays 0.
REQ-021 start at cycle t -> bias_valid=1 at t+1 with the contents of base_addr; latency exactly one cycle.
REQ-022 In STREAM, bias_data, bias_addr and bias_valid hold stable while bias_valid=1 and bias_ready=0.
REQ-023 A transfer is a cycle with bias_valid=1 and bias_ready=1; after it, the next cycle presents the vector at bias_addr+1 (modulo DEPTH, wraps DEPTH-1 -> 0) with no bubble.
REQ-024 After the count-th transfer: next cycle state=IDLE, bias_valid=0, busy=0, done=1 for exactly one cycle.
REQ-025 start while busy=1 is ignored; the stream in progress is unaffected.
REQ-026 A lane write updates only lane ld_lane of vector ld_addr; other lanes are unchanged; writes are accepted in any state.
REQ-027 A lane write and a read of the same vector in the same cycle: the read returns the pre-write value; the new value is visible on the next read of that vector.
REQ-028 The vector currently held on bias_data is not changed by a later write to its address.
REQ-029 ld_lane >= PE_NUM: the write is discarded.
REQ-030 Storage is not initialised; software loads every vector before streaming it.

Reset
REQ-031 rst_n=0 at a clock edge -> state IDLE; bias_valid, busy, done = 0; bias_data, bias_addr = 0; internal counters = 0.
REQ-032 Reset mid-stream aborts the stream with no done pulse; stored bias contents are retained.
REQ-033 start or ld_en asserted during reset is ignored.

Structure
REQ-034 Package bias_pkg holds the state enumeration and the default DWIDTH/PE_NUM/DEPTH constants.
REQ-035 Sub-module bias_mem: DEPTH x PE_NUM x DWIDTH lane-writable array with one synchronous read port (read-before-write), instantiated once.
REQ-036 The stream FSM, address/remaining counters and output register reside in bias_buffer; RTL 120-400 lines total.

Verification
REQ-037 Load vector 3 lanes 0..7 = -1,2,-3,4,-5,6,-7,8; start base=3 count=1, ready=1 -> valid at t+1, bias_addr=3, lanes as loaded, done at t+2.
REQ-038 DEPTH=32, start base=30 count=4, ready=1 -> addresses 30,31,0,1 on consecutive cycles, then done pulse.
REQ-039 Stream count=3 with ready low for 5 cycles on 2nd vector -> data/addr stable for those cycles, exactly 3 transfers, single done pulse.
REQ-040 While vector 5 is presented with ready=0, write lane 2 of vector 5 = 0x7FFF -> output unchanged; next stream of 5 shows lane 2 = 0x7FFF.
REQ-041 start count=0 -> no valid, done one cycle later; start while busy -> ignored; rst_n low mid-stream -> all outputs 0 next cycle, no done, contents retained on restream.
